// File: rtl/exc_sequencer_pkg.sv
// rtl/exc_sequencer_pkg.sv - shared state encodings and CP0 ExcCode constants for the trap sequencer
package exc_sequencer_pkg;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_TRAP  = 2'd1,
      ST_ERET  = 2'd2,
      ST_DRAIN = 2'd3
   } seq_state_t;

   localparam logic [31:0] HANDLER_PC_DEF = 32'h0000_4180;

   localparam logic [4:0] EXC_INT  = 5'd0;
   localparam logic [4:0] EXC_ADEL = 5'd4;
   localparam logic [4:0] EXC_ADES = 5'd5;
   localparam logic [4:0] EXC_RI   = 5'd10;
   localparam logic [4:0] EXC_OV   = 5'd12;

endpackage

// File: rtl/exc_sequencer_if.sv
// rtl/exc_sequencer_if.sv - M-stage/CP0 inputs and trap strobes/redirect outputs of the sequencer
interface exc_sequencer_if;
   logic        m_valid;
   logic [31:0] pc_m;
   logic        bd_m;
   logic [4:0]  exc_code_m;
   logic        eret_m;
   logic        mtc0_sr_m;
   logic [5:0]  hw_int;
   logic [5:0]  sr_im;
   logic        sr_ie;
   logic        sr_exl;
   logic [31:0] epc;

   logic        exl_set;
   logic        exl_clr;
   logic [4:0]  cp0_exc_code;
   logic        cp0_bd;
   logic [31:0] cp0_pc;
   logic        flush;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        busy;

   modport master (
      output m_valid, pc_m, bd_m, exc_code_m, eret_m, mtc0_sr_m,
             hw_int, sr_im, sr_ie, sr_exl, epc,
      input  exl_set, exl_clr, cp0_exc_code, cp0_bd, cp0_pc,
             flush, redirect, redirect_pc, busy
   );

   modport slave (
      input  m_valid, pc_m, bd_m, exc_code_m, eret_m, mtc0_sr_m,
             hw_int, sr_im, sr_ie, sr_exl, epc,
      output exl_set, exl_clr, cp0_exc_code, cp0_bd, cp0_pc,
             flush, redirect, redirect_pc, busy
   );
endinterface

// File: rtl/exc_drain_cnt.sv
// rtl/exc_drain_cnt.sv - loadable down-counter that stops at zero, used for drain and MTC0 guard
module exc_drain_cnt #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic [W-1:0] count
);

   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (count != '0) begin
         count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/exc_sequencer.sv
// rtl/exc_sequencer.sv - picks one trap event per cycle at M, drives CP0 strobes, flush and PC redirect
module exc_sequencer
   import exc_sequencer_pkg::*;
#(
   parameter logic [31:0] HANDLER_PC   = HANDLER_PC_DEF,
   parameter int          DRAIN_CYCLES = 2,
   parameter int          MTC0_GUARD   = 1
) (
   input  logic           clk,
   input  logic           reset,
   exc_sequencer_if.slave bus
);

   seq_state_t state;
   logic [2:0] drain_cnt;
   logic [1:0] guard_cnt;
   logic       in_run;
   logic       exc_ev;
   logic       irq_ev;
   logic       ert_ev;
   logic       accept;
   logic       drain_load;
   logic       guard_load;

   always_comb begin
      in_run = (state == ST_RUN);
      exc_ev = in_run & bus.m_valid & (bus.exc_code_m != 5'd0) & ~bus.sr_exl;
      irq_ev = in_run & bus.m_valid & (|(bus.hw_int & bus.sr_im)) & bus.sr_ie
               & ~bus.sr_exl & (guard_cnt == 2'd0);
      ert_ev = in_run & bus.m_valid & bus.eret_m & (bus.exc_code_m == 5'd0);
      accept = exc_ev | irq_ev | ert_ev;
      drain_load = (state == ST_TRAP) | (state == ST_ERET);
      // An MTC0 that coincides with an accepted trap is squashed, so it must not arm the guard
      guard_load = in_run & bus.m_valid & bus.mtc0_sr_m & ~accept;
   end

   exc_drain_cnt #(.W(3)) u_drain_cnt (
      .clk      (clk),
      .reset    (reset),
      .load     (drain_load),
      .load_val (3'(DRAIN_CYCLES - 1)),
      .count    (drain_cnt)
   );

   exc_drain_cnt #(.W(2)) u_guard_cnt (
      .clk      (clk),
      .reset    (reset),
      .load     (guard_load),
      .load_val (2'(MTC0_GUARD)),
      .count    (guard_cnt)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state            <= ST_RUN;
         bus.exl_set      <= 1'b0;
         bus.exl_clr      <= 1'b0;
         bus.flush        <= 1'b0;
         bus.redirect     <= 1'b0;
         bus.redirect_pc  <= 32'd0;
         bus.cp0_exc_code <= 5'd0;
         bus.cp0_bd       <= 1'b0;
         bus.cp0_pc       <= 32'd0;
         bus.busy         <= 1'b0;
      end else begin
         bus.exl_set  <= 1'b0;
         bus.exl_clr  <= 1'b0;
         bus.flush    <= 1'b0;
         bus.redirect <= 1'b0;
         case (state)
            ST_RUN: begin
               if (exc_ev || irq_ev) begin
                  bus.cp0_exc_code <= exc_ev ? bus.exc_code_m : EXC_INT;
                  bus.cp0_bd       <= bus.bd_m;
                  bus.cp0_pc       <= bus.pc_m;
                  bus.exl_set      <= 1'b1;
                  bus.flush        <= 1'b1;
                  bus.redirect     <= 1'b1;
                  bus.redirect_pc  <= HANDLER_PC;
                  bus.busy         <= 1'b1;
                  state            <= ST_TRAP;
               end else if (ert_ev) begin
                  bus.exl_clr     <= 1'b1;
                  bus.flush       <= 1'b1;
                  bus.redirect    <= 1'b1;
                  bus.redirect_pc <= bus.epc;
                  bus.busy        <= 1'b1;
                  state           <= ST_ERET;
               end
            end
            ST_TRAP, ST_ERET: begin
               state <= ST_DRAIN;
            end
            ST_DRAIN: begin
               if (drain_cnt == 3'd0) begin
                  state    <= ST_RUN;
                  bus.busy <= 1'b0;
               end
            end
            default: begin
               state    <= ST_RUN;
               bus.busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_exc_sequencer.sv
// tb/tb_exc_sequencer.sv - scoreboard bench for exc_sequencer trap, interrupt, ERET, guard and reset behaviour
module tb_exc_sequencer;

   localparam logic [31:0] HPC   = 32'h0000_4180;
   localparam int          DRAIN = 2;
   localparam int          GUARD = 1;

   typedef struct {
      int          cyc;
      logic        eret;
      logic [4:0]  code;
      logic        bd;
      logic [31:0] pc;
      logic [31:0] rpc;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;
   exp_t sb[$];

   exc_sequencer_if bus ();

   exc_sequencer #(
      .HANDLER_PC   (HPC),
      .DRAIN_CYCLES (DRAIN),
      .MTC0_GUARD   (GUARD)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
      n_tests++;
      if (obs !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.m_valid    = 1'b0;
      bus.pc_m       = 32'd0;
      bus.bd_m       = 1'b0;
      bus.exc_code_m = 5'd0;
      bus.eret_m     = 1'b0;
      bus.mtc0_sr_m  = 1'b0;
      bus.hw_int     = 6'd0;
   endtask

   task automatic push(input int c, input logic er, input logic [4:0] code,
                       input logic bd, input logic [31:0] pc, input logic [31:0] rpc);
      exp_t e;
      e.cyc = c; e.eret = er; e.code = code; e.bd = bd; e.pc = pc; e.rpc = rpc;
      sb.push_back(e);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 20 && bus.busy; i++) tick();
      check("idle_timeout", {31'd0, bus.busy}, 32'd0);
   endtask

   // Every redirect pulse must match the oldest expectation, including the cycle it appears in
   always @(negedge clk) begin
      if (bus.redirect === 1'b1) begin
         if (sb.size() == 0) begin
            check("spurious_redirect", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("redirect_cycle", cyc, e.cyc);
            check("flush", {31'd0, bus.flush}, 32'd1);
            check("redirect_pc", bus.redirect_pc, e.rpc);
            check("exl_set", {31'd0, bus.exl_set}, {31'd0, ~e.eret});
            check("exl_clr", {31'd0, bus.exl_clr}, {31'd0, e.eret});
            if (!e.eret) begin
               check("cp0_exc_code", {27'd0, bus.cp0_exc_code}, {27'd0, e.code});
               check("cp0_bd", {31'd0, bus.cp0_bd}, {31'd0, e.bd});
               check("cp0_pc", bus.cp0_pc, e.pc);
            end
         end
      end
   end

   initial begin
      reset = 1'b1;
      idle_inputs();
      bus.sr_im  = 6'd0;
      bus.sr_ie  = 1'b0;
      bus.sr_exl = 1'b0;
      bus.epc    = 32'd0;
      repeat (3) tick();
      check("rst_exl_set", {31'd0, bus.exl_set}, 32'd0);
      check("rst_flush", {31'd0, bus.flush}, 32'd0);
      check("rst_redirect_pc", bus.redirect_pc, 32'd0);
      check("rst_cp0_pc", bus.cp0_pc, 32'd0);
      check("rst_busy", {31'd0, bus.busy}, 32'd0);
      reset = 1'b0;
      tick();

      // Overflow at M: trap, then DRAIN for DRAIN cycles, back to RUN
      bus.m_valid = 1'b1; bus.exc_code_m = 5'd12; bus.pc_m = 32'h3010;
      push(cyc + 1, 1'b0, 5'd12, 1'b0, 32'h3010, HPC);
      tick();
      idle_inputs();
      check("ov_busy_trap", {31'd0, bus.busy}, 32'd1);
      for (int i = 0; i < DRAIN; i++) begin
         tick();
         check("ov_busy_drain", {31'd0, bus.busy}, 32'd1);
      end
      tick();
      check("ov_busy_done", {31'd0, bus.busy}, 32'd0);
      check("ov_code_hold", {27'd0, bus.cp0_exc_code}, 32'd12);
      check("ov_pc_hold", bus.cp0_pc, 32'h3010);

      // Interrupt on a delay-slot instruction
      bus.sr_im = 6'b000100; bus.sr_ie = 1'b1;
      bus.m_valid = 1'b1; bus.hw_int = 6'b000100; bus.bd_m = 1'b1; bus.pc_m = 32'h3024;
      push(cyc + 1, 1'b0, 5'd0, 1'b1, 32'h3024, HPC);
      tick();
      idle_inputs();
      wait_idle();

      // AdEL together with a pending interrupt: exception first, interrupt after drain
      bus.m_valid = 1'b1; bus.hw_int = 6'b000100; bus.exc_code_m = 5'd4; bus.pc_m = 32'h3050;
      push(cyc + 1, 1'b0, 5'd4, 1'b0, 32'h3050, HPC);
      tick();
      bus.exc_code_m = 5'd0; bus.pc_m = 32'h3054;
      push(cyc + 2 + DRAIN, 1'b0, 5'd0, 1'b0, 32'h3054, HPC);
      repeat (2 + DRAIN) tick();
      idle_inputs();
      wait_idle();

      // ERET returns to EPC
      bus.epc = 32'h3040; bus.m_valid = 1'b1; bus.eret_m = 1'b1;
      push(cyc + 1, 1'b1, 5'd0, 1'b0, 32'd0, 32'h3040);
      tick();
      idle_inputs();
      wait_idle();

      // MTC0 to SR masks an interrupt for GUARD cycles
      bus.m_valid = 1'b1; bus.mtc0_sr_m = 1'b1; bus.pc_m = 32'h305c;
      tick();
      bus.mtc0_sr_m = 1'b0; bus.hw_int = 6'b000100; bus.pc_m = 32'h3060;
      push(cyc + 1 + GUARD, 1'b0, 5'd0, 1'b0, 32'h3060, HPC);
      repeat (1 + GUARD) tick();
      idle_inputs();
      wait_idle();

      // Interrupt with a bubble at M waits for a real instruction
      bus.hw_int = 6'b000100;
      repeat (3) tick();
      check("bubble_no_trap", {31'd0, bus.busy}, 32'd0);
      bus.m_valid = 1'b1; bus.pc_m = 32'h3070;
      push(cyc + 1, 1'b0, 5'd0, 1'b0, 32'h3070, HPC);
      tick();
      idle_inputs();
      wait_idle();

      // Exception while EXL is set is ignored
      bus.sr_exl = 1'b1; bus.m_valid = 1'b1; bus.exc_code_m = 5'd10; bus.pc_m = 32'h3078;
      repeat (2) tick();
      check("exl_ignore_busy", {31'd0, bus.busy}, 32'd0);
      idle_inputs();
      bus.sr_exl = 1'b0;
      tick();

      // Reset while in TRAP clears everything; the next exception is taken immediately
      bus.m_valid = 1'b1; bus.exc_code_m = 5'd5; bus.pc_m = 32'h3080;
      push(cyc + 1, 1'b0, 5'd5, 1'b0, 32'h3080, HPC);
      tick();
      idle_inputs();
      reset = 1'b1;
      tick();
      check("trst_exl_set", {31'd0, bus.exl_set}, 32'd0);
      check("trst_flush", {31'd0, bus.flush}, 32'd0);
      check("trst_redirect", {31'd0, bus.redirect}, 32'd0);
      check("trst_redirect_pc", bus.redirect_pc, 32'd0);
      check("trst_cp0_code", {27'd0, bus.cp0_exc_code}, 32'd0);
      check("trst_cp0_pc", bus.cp0_pc, 32'd0);
      check("trst_busy", {31'd0, bus.busy}, 32'd0);
      reset = 1'b0;
      bus.m_valid = 1'b1; bus.exc_code_m = 5'd10; bus.pc_m = 32'h3090;
      push(cyc + 1, 1'b0, 5'd10, 1'b0, 32'h3090, HPC);
      tick();
      idle_inputs();
      wait_idle();

      repeat (4) tick();
      check("scoreboard_empty", sb.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/exc_sequencer.md
# exc_sequencer

Exception/interrupt sequencer for the P7 five-stage MIPS pipeline. It watches the M stage and the CP0 status bits, picks one trap event per cycle (exception, interrupt or ERET) and drives the CP0 update strobes. It also drives the pipeline-wide flush and the PC redirect to the handler entry or to EPC, then holds off further traps until the flush has drained. It sits between the M-stage pipeline register, the cp0 block and the F-stage PC mux.

## Interface
- HANDLER_PC, 32'h0000_4180, exception/interrupt handler entry address
- DRAIN_CYCLES, 2, cycles in DRAIN after a redirect (range 1..7)
- MTC0_GUARD, 1, cycles interrupts stay masked after an MTC0 to SR (range 0..3)

- clk  in  1  clock
- reset  in  1  synchronous, active-high
- m_valid  in  1  M stage holds a real instruction, not a bubble
- pc_m  in  32  PC of the M-stage instruction
- bd_m  in  1  M-stage instruction is in a delay slot
- exc_code_m  in  5  accumulated exception code of the M-stage instruction; 0 means none
- eret_m  in  1  M-stage instruction is ERET
- mtc0_sr_m  in  1  M-stage instruction is MTC0 to register 12
- hw_int  in  6  external interrupt lines
- sr_im  in  6  SR.IM from CP0
- sr_ie  in  1  SR.IE from CP0
- sr_exl  in  1  SR.EXL from CP0
- epc  in  32  current CP0 EPC
- exl_set  out  1  one-cycle strobe to CP0: set EXL and latch cause/EPC
- exl_clr  out  1  one-cycle strobe to CP0: clear EXL
- cp0_exc_code  out  5  ExcCode to write into Cause (0 for interrupt)
- cp0_bd  out  1  BD to write into Cause
- cp0_pc  out  32  PC to write into EPC; CP0 subtracts 4 when BD is set
- flush  out  1  squash F/D/E/M instructions and block the M-stage write-back and memory write
- redirect  out  1  F-stage PC mux selects redirect_pc
- redirect_pc  out  32  target PC
- busy  out  1  state is not RUN

## Operation
- States: RUN, TRAP, ERET, DRAIN. Reset forces RUN, clears the guard counter and the drain counter, and drives all outputs to 0.
- Event evaluation happens in RUN only, combinationally, from the M-stage inputs:
  - exc = m_valid & exc_code_m≠0 & !sr_exl
  - irq = m_valid & |(hw_int & sr_im) & sr_ie & !sr_exl & guard==0
  - ert = m_valid & eret_m & exc_code_m==0
- Priority: exc > irq > ert. Only one event is accepted per cycle.
- On exc or irq:
  - latch code (exc_code_m for exc, 0 for irq), bd_m and pc_m into output registers;
  - go to TRAP.
- On ert: latch epc into the redirect_pc register; go to ERET.
- TRAP (1 cycle): exl_set=1, flush=1, redirect=1, redirect_pc=HANDLER_PC; cp0_* outputs hold the latched values. Next state is DRAIN.
- ERET (1 cycle): exl_clr=1, flush=1, redirect=1, redirect_pc=latched EPC. Next state is DRAIN.
- DRAIN: load the counter with DRAIN_CYCLES-1 on entry and decrement each cycle. Return to RUN when the counter reaches 0. No events are accepted in DRAIN.
- Guard counter:
  - mtc0_sr_m & m_valid in RUN, with no event accepted, loads MTC0_GUARD;
  - otherwise the counter decrements while nonzero;
  - the guard blocks irq only, never exc or ert.
- Interrupt arriving while m_valid=0: it is deferred. The request is re-evaluated every cycle, and no latching happens until a valid M instruction is present.
- The block stores no hw_int state. An interrupt line dropped before acceptance is lost.
- An exc arriving while sr_exl=1 is ignored; the pipeline continues without a redirect.

## Timing
- Event detected in cycle N (RUN) → TRAP or ERET outputs registered and visible in cycle N+1 → DRAIN for cycles N+2 .. N+1+DRAIN_CYCLES → RUN in cycle N+2+DRAIN_CYCLES.
- Minimum spacing between two accepted events: 2+DRAIN_CYCLES cycles.
- exl_set, exl_clr, flush and redirect are all single-cycle pulses. exl_set and exl_clr are never high together.
- cp0_exc_code, cp0_bd and cp0_pc stay stable from TRAP until the next accepted event.
- Reset asserted in any state: outputs are 0 in the following cycle and state is RUN. No partial pulse is extended.

## Structure
- Shared package/header (the macrodefine file): state encodings, HANDLER_PC default, ExcCode constants (Int=0, AdEL=4, AdES=5, RI=10, Ov=12).
- One sub-module, exc_drain_cnt: a loadable down-counter reused for both the drain counter and the guard counter.

## Test plan
- Ov at M: exc_code_m=12, pc_m=0x3010, bd_m=0, sr_exl=0 → next cycle exl_set=1, flush=1, redirect_pc=0x4180, cp0_exc_code=12, cp0_pc=0x3010; busy low after 2+DRAIN_CYCLES cycles.
- Interrupt in delay slot: hw_int=6'b000100, sr_im=6'b000100, sr_ie=1, bd_m=1, pc_m=0x3024 → cp0_exc_code=0, cp0_bd=1, cp0_pc=0x3024.
- Simultaneous exc_code_m=4 and a pending interrupt → exception wins, cp0_exc_code=4; the interrupt is taken only after DRAIN, if still asserted.
- ERET with epc=0x3040 → exl_clr=1, redirect_pc=0x3040, exl_set stays 0.
- MTC0 to SR with MTC0_GUARD=1 and an interrupt pending next cycle → no trap that cycle, trap the following cycle. Interrupt while m_valid=0 → no trap until m_valid=1.
- Reset asserted in TRAP → the next cycle shows all outputs 0 and busy=0.
